ff_fifo: RTL and testbench
==========================

# ff_fifo

Parametrised flip-flop-based FIFO for the input buffer: DEPTH entries of WIDTH bits with a valid/ready handshake on each side, a first-word-fall-through read port, and an occupancy count. Writes are synchronous and reads are combinational from the head entry. An optional associative search reports whether any occupied entry matches a key. It replaces single-word registered storage wherever the input path must absorb bursts.

## Interface
- WIDTH, 16, data bits per entry (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush_i  in  1  synchronous clear of occupancy (pointers/count), storage untouched
- wr_valid_i  in  1  producer offers wr_data_i
- wr_data_i  in  WIDTH  write data
- wr_ready_o  out  1  FIFO can accept (= !full_o)
- rd_valid_o  out  1  head entry present (= !empty_o)
- rd_data_o  out  WIDTH  head entry when rd_valid_o, else all-zero
- rd_ready_i  in  1  consumer takes head
- count_o  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- search_key_i  in  WIDTH  key for associative search
- search_hit_o  out  1  some occupied entry equals search_key_i
- search_idx_o  out  $clog2(DEPTH)  queue position (0 = head) of oldest match

## Operation
- Push = wr_valid_i & wr_ready_o; pop = rd_valid_o & rd_ready_i; each evaluated in the same cycle.
- Push: entry[wr_ptr] <= wr_data_i, wr_ptr++ (wraps DEPTH-1 -> 0).
- Pop: rd_ptr++ (wraps); popped entry not cleared.
- count_o: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full: wr_ready_o=0, wr_valid_i ignored; a pop in the same cycle does not enable a push (no write-through when full).
- Empty: rd_valid_o=0, rd_data_o='0, rd_ready_i ignored; a push into an empty FIFO is not bypassed to the read port.
- Push and pop together at 0<count<DEPTH: both performed, count unchanged.
- flush_i: rd_ptr, wr_ptr, count <= 0; has priority over a push/pop in the same cycle (both discarded).
- Reset: pointers, count, and all storage cleared to 0; asynchronous assertion, synchronous-safe release.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty derive from count_o, never from pointer comparison.

## Timing
- Reset values: wr_ready_o=1, rd_valid_o=0, rd_data_o=0, count_o=0, full_o=0, empty_o=1, search_hit_o=0, search_idx_o=0.
- Write-to-read latency: 1 cycle (data pushed at edge N is on rd_data_o after edge N).
- rd_data_o, status outputs, and search outputs are combinational from registered state (search also from search_key_i); no input-to-output path other than the search key.
- Throughput: one push and one pop per cycle.

## Configuration
- FF_FIFO_SEARCH_EN defined: per-entry comparators present; search_hit_o/search_idx_o as above, considering only occupied entries, with the lowest queue position winning.
- Undefined: comparators removed; ports remain, search_hit_o=0, search_idx_o=0, search_key_i unused.

## Structure
- Package ff_fifo_pkg: default WIDTH/DEPTH constants and a helper function returning the count width ($clog2(DEPTH)+1); parameter-dependent typedefs are declared locally.
- Sub-module ff_fifo_entry: one WIDTH-bit register with write enable and async reset, plus a key-equality output (tied 0 when FF_FIFO_SEARCH_EN is absent); instantiated DEPTH times via generate.

## Test plan
- Reset, then push 0x0001..0x0008 (DEPTH=8, no reads) -> full_o=1, count_o=8, wr_ready_o=0; a 9th push of 0x0009 is dropped; 8 pops return 0x0001..0x0008 in order, then empty_o=1 and rd_data_o=0.
- Continuous push+pop for 20 cycles at count=3 -> count_o stays 3, data order preserved across pointer wrap.
- Full FIFO with wr_valid_i=1, rd_ready_i=1 in the same cycle -> pop only, count_o 8 -> 7, new data not written.
- count=5 with flush_i=1, wr_valid_i=1, rd_ready_i=1 -> next cycle count_o=0, empty_o=1, rd_data_o=0.
- FF_FIFO_SEARCH_EN: queue {0x00AA, 0x0055, 0x00AA}, key 0x00AA -> hit=1, idx=0; pop once -> idx=1; key 0x1234 -> hit=0; a popped stale value is never reported as a hit.
- Assert reset mid-burst (count=4) between edges -> outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ff_fifo_pkg.sv
// ff_fifo_pkg: shared defaults for the flip-flop FIFO.
//   FF_FIFO_WIDTH / FF_FIFO_DEPTH : default data width and entry count
//   count_width(depth)            : width of an occupancy counter covering 0..depth
package ff_fifo_pkg;

  localparam int FF_FIFO_WIDTH = 16;
  localparam int FF_FIFO_DEPTH = 8;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ff_fifo_entry.sv
// ff_fifo_entry: one storage word of the FIFO with a key comparator.
// Optional feature macro: FF_FIFO_SEARCH_EN (comparator present when defined,
// match tied low otherwise).
// Ports:
//   clk, reset : clock, asynchronous active-high reset (clears the word)
//   we, d      : write enable and write data
//   key        : search key
//   q          : stored word
//   match      : q equals key
module ff_fifo_entry
  import ff_fifo_pkg::*;
#(
  parameter int WIDTH = FF_FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] q,
  output logic             match
);

  // NOTE: storage words are reset like any other state so a cleared FIFO
  // never exposes old data through the search comparators or read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

`ifdef FF_FIFO_SEARCH_EN
  assign match = (q == key);
`else
  logic unused_key;
  assign unused_key = ^key;
  assign match      = 1'b0;
`endif

endmodule

// File: rtl/ff_fifo.sv
// ff_fifo: flip-flop FIFO with valid/ready handshakes, first-word-fall-through
// read port, occupancy count and optional associative search.
// Optional feature macro: FF_FIFO_SEARCH_EN (search outputs driven when defined,
// tied to zero otherwise).
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   flush_i                     : synchronous clear of pointers and count
//   wr_valid_i/wr_data_i/wr_ready_o : write handshake
//   rd_valid_o/rd_data_o/rd_ready_i : read handshake, head entry combinational
//   count_o, full_o, empty_o    : occupancy status
//   search_key_i, search_hit_o, search_idx_o : oldest occupied entry matching key
module ff_fifo
  import ff_fifo_pkg::*;
#(
  parameter int WIDTH = FF_FIFO_WIDTH,
  parameter int DEPTH = FF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     wr_valid_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic                     wr_ready_o,
  output logic                     rd_valid_o,
  output logic [WIDTH-1:0]         rd_data_o,
  input  logic                     rd_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  input  logic [WIDTH-1:0]         search_key_i,
  output logic                     search_hit_o,
  output logic [$clog2(DEPTH)-1:0] search_idx_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  ptr_t             wr_ptr, rd_ptr;
  cnt_t             count_q;
  logic             push, pop, wr_en;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] match;

  // Status comes from the counter alone; pointers are equal both when empty and full.
  assign full_o     = (count_q == cnt_t'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign wr_ready_o = !full_o;
  assign rd_valid_o = !empty_o;
  assign rd_data_o  = empty_o ? '0 : mem[rd_ptr];

  // Push while full is refused even if a pop frees a slot this cycle.
  assign push  = wr_valid_i && !full_o;
  assign pop   = rd_ready_i && !empty_o;
  assign wr_en = push && !flush_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      if (push && !pop)      count_q <= count_q + cnt_t'(1);
      else if (pop && !push) count_q <= count_q - cnt_t'(1);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    ff_fifo_entry #(.WIDTH(WIDTH)) u_entry (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en && (wr_ptr == ptr_t'(i))),
      .d     (wr_data_i),
      .key   (search_key_i),
      .q     (mem[i]),
      .match (match[i])
    );
  end

`ifdef FF_FIFO_SEARCH_EN
  // Walk queue positions from the head so the oldest occupied match wins;
  // positions at or beyond count hold stale words and are skipped.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic found;
    found        = 1'b0;
    search_hit_o = 1'b0;
    search_idx_o = '0;
    for (int p = 0; p < DEPTH; p++) begin
      if (!found && (cnt_t'(p) < count_q) && match[rd_ptr + ptr_t'(p)]) begin
        found        = 1'b1;
        search_hit_o = 1'b1;
        search_idx_o = ptr_t'(p);
      end
    end
  end
`else
  logic unused_match;
  assign unused_match = |match;
  assign search_hit_o = 1'b0;
  assign search_idx_o = '0;
`endif

endmodule

// File: tb/tb_ff_fifo.sv
// tb_ff_fifo: self-checking bench for ff_fifo (WIDTH=16, DEPTH=8).
// A queue of expected words is filled as data is pushed and drained as the
// FIFO presents its head on a pop.
module tb_ff_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush_i = 1'b0;
  logic             wr_valid_i = 1'b0;
  logic [WIDTH-1:0] wr_data_i = '0;
  logic             wr_ready_o;
  logic             rd_valid_o;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_ready_i = 1'b0;
  logic [3:0]       count_o;
  logic             full_o;
  logic             empty_o;
  logic [WIDTH-1:0] search_key_i = '0;
  logic             search_hit_o;
  logic [2:0]       search_idx_o;

  int               passed = 0;
  int               total  = 0;
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] exp_word;

  always #5 clk = ~clk;

  ff_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .wr_valid_i   (wr_valid_i),
    .wr_data_i    (wr_data_i),
    .wr_ready_o   (wr_ready_o),
    .rd_valid_o   (rd_valid_o),
    .rd_data_o    (rd_data_o),
    .rd_ready_i   (rd_ready_i),
    .count_o      (count_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .search_key_i (search_key_i),
    .search_hit_o (search_hit_o),
    .search_idx_o (search_idx_o)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = base + WIDTH'(i);
      exp_q.push_back(wr_data_i);
      tick();
    end
    wr_valid_i = 1'b0;
  endtask

  // Pops every word the model still expects, comparing each head before its edge.
  task automatic drain(input string tag);
    rd_ready_i = 1'b1;
    while (exp_q.size() > 0) begin
      exp_word = exp_q.pop_front();
      total++;
      if (rd_valid_o !== 1'b1 || rd_data_o !== exp_word)
        $display("FAIL %s_pop got valid=%b data=%h expected valid=1 data=%h",
                 tag, rd_valid_o, rd_data_o, exp_word);
      else passed++;
      tick();
    end
    rd_ready_i = 1'b0;
    total++;
    if (empty_o !== 1'b1 || rd_data_o !== '0 || count_o !== 4'd0)
      $display("FAIL %s_empty got empty=%b data=%h count=%0d expected empty=1 data=0000 count=0",
               tag, empty_o, rd_data_o, count_o);
    else passed++;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({wr_ready_o, rd_valid_o, full_o, empty_o, search_hit_o} !== 5'b10010 ||
        count_o !== 4'd0 || rd_data_o !== '0 || search_idx_o !== 3'd0)
      $display("FAIL reset_values got wr_ready=%b rd_valid=%b full=%b empty=%b hit=%b count=%0d data=%h idx=%0d expected 1 0 0 1 0 0 0000 0",
               wr_ready_o, rd_valid_o, full_o, empty_o, search_hit_o, count_o, rd_data_o, search_idx_o);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    push_words(DEPTH, 16'h0001);
    total++;
    if (full_o !== 1'b1 || count_o !== 4'd8 || wr_ready_o !== 1'b0)
      $display("FAIL fill_full got full=%b count=%0d wr_ready=%b expected 1 8 0",
               full_o, count_o, wr_ready_o);
    else passed++;
    wr_valid_i = 1'b1;
    wr_data_i  = 16'h0009;
    tick();
    wr_valid_i = 1'b0;
    total++;
    if (count_o !== 4'd8)
      $display("FAIL ninth_push_dropped got count=%0d expected 8", count_o);
    else passed++;
    drain("fill");
  endtask

  task automatic test_back_to_back();
    push_words(3, 16'h0100);
    wr_valid_i = 1'b1;
    rd_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data_i = 16'h0200 + WIDTH'(i);
      exp_word  = exp_q.pop_front();
      exp_q.push_back(wr_data_i);
      total++;
      if (rd_data_o !== exp_word)
        $display("FAIL b2b_data cycle %0d got %h expected %h", i, rd_data_o, exp_word);
      else passed++;
      tick();
      total++;
      if (count_o !== 4'd3)
        $display("FAIL b2b_count cycle %0d got %0d expected 3", i, count_o);
      else passed++;
    end
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    drain("b2b");
  endtask

  task automatic test_full_push_pop();
    push_words(DEPTH, 16'h0300);
    wr_valid_i = 1'b1;
    wr_data_i  = 16'hDEAD;
    rd_ready_i = 1'b1;
    exp_word   = exp_q.pop_front();
    total++;
    if (rd_data_o !== exp_word)
      $display("FAIL full_pp_head got %h expected %h", rd_data_o, exp_word);
    else passed++;
    tick();
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    total++;
    if (count_o !== 4'd7 || full_o !== 1'b0)
      $display("FAIL full_pp_count got count=%0d full=%b expected 7 0", count_o, full_o);
    else passed++;
    drain("full_pp");
  endtask

  task automatic test_flush();
    push_words(5, 16'h0400);
    flush_i    = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_i  = 16'hBEEF;
    rd_ready_i = 1'b1;
    tick();
    flush_i    = 1'b0;
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    exp_q.delete();
    total++;
    if (count_o !== 4'd0 || empty_o !== 1'b1 || rd_data_o !== '0)
      $display("FAIL flush got count=%0d empty=%b data=%h expected 0 1 0000",
               count_o, empty_o, rd_data_o);
    else passed++;
    push_words(2, 16'h0500);
    drain("post_flush");
  endtask

  task automatic test_search();
`ifdef FF_FIFO_SEARCH_EN
    wr_valid_i = 1'b1;
    wr_data_i = 16'h00AA; exp_q.push_back(wr_data_i); tick();
    wr_data_i = 16'h0055; exp_q.push_back(wr_data_i); tick();
    wr_data_i = 16'h00AA; exp_q.push_back(wr_data_i); tick();
    wr_valid_i   = 1'b0;
    search_key_i = 16'h00AA;
    #1;
    total++;
    if (search_hit_o !== 1'b1 || search_idx_o !== 3'd0)
      $display("FAIL search_oldest got hit=%b idx=%0d expected 1 0", search_hit_o, search_idx_o);
    else passed++;
    rd_ready_i = 1'b1;
    void'(exp_q.pop_front());
    tick();
    rd_ready_i = 1'b0;
    total++;
    if (search_hit_o !== 1'b1 || search_idx_o !== 3'd1)
      $display("FAIL search_after_pop got hit=%b idx=%0d expected 1 1", search_hit_o, search_idx_o);
    else passed++;
    search_key_i = 16'h1234;
    #1;
    total++;
    if (search_hit_o !== 1'b0)
      $display("FAIL search_miss got hit=%b expected 0", search_hit_o);
    else passed++;
    rd_ready_i = 1'b1;
    void'(exp_q.pop_front());
    tick();
    rd_ready_i   = 1'b0;
    search_key_i = 16'h0055;
    #1;
    total++;
    if (search_hit_o !== 1'b0)
      $display("FAIL search_stale got hit=%b expected 0", search_hit_o);
    else passed++;
    drain("search");
    search_key_i = 16'h00AA;
    #1;
    total++;
    if (search_hit_o !== 1'b0)
      $display("FAIL search_empty_stale got hit=%b expected 0", search_hit_o);
    else passed++;
`else
    push_words(2, 16'h0600);
    search_key_i = 16'h0600;
    #1;
    total++;
    if (search_hit_o !== 1'b0 || search_idx_o !== 3'd0)
      $display("FAIL search_disabled got hit=%b idx=%0d expected 0 0", search_hit_o, search_idx_o);
    else passed++;
    drain("search_off");
`endif
  endtask

  task automatic test_async_reset();
    push_words(4, 16'h0700);
    total++;
    if (count_o !== 4'd4)
      $display("FAIL async_pre got count=%0d expected 4", count_o);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    total++;
    if (count_o !== 4'd0 || empty_o !== 1'b1 || rd_valid_o !== 1'b0 ||
        rd_data_o !== '0 || wr_ready_o !== 1'b1 || full_o !== 1'b0)
      $display("FAIL async_reset got count=%0d empty=%b rd_valid=%b data=%h wr_ready=%b full=%b expected 0 1 0 0000 1 0",
               count_o, empty_o, rd_valid_o, rd_data_o, wr_ready_o, full_o);
    else passed++;
    tick();
    reset = 1'b0;
    tick();
    push_words(1, 16'h0800);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_push_pop();
    test_flush();
    test_search();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
